wb_interconnect_1xn: RTL

- Parametrised single-master, N-slave Wishbone classic interconnect that replaces the hard-coded combinational device select, stb, data and ack muxing in the SoC top level.
- Address map is supplied as base/mask parameter vectors.
- The selected slave is registered at cycle start and held for the whole transaction.
- Unmapped accesses and hung slaves terminate with wbm_err_o instead of stopping simulation.
- Sits between the core dbus master and the memory/UART/GPIO slaves.

---
 rtl/wb_ic_pkg.sv | 14 +
 rtl/wb_addr_decoder.sv | 23 ++
 rtl/wb_interconnect_1xn.sv | 100 ++++++++++
 3 files changed

// File: rtl/wb_ic_pkg.sv
// wb_ic_pkg: shared FSM encodings, default SoC address map and select-index sizing for the Wishbone 1xN interconnect.
package wb_ic_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERR = 2'd2;
  localparam int DEF_NUM_SLAVES = 5;
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLAVE_BASE =
    {32'h08000104, 32'h08000100, 32'h08000000, 32'h04000000, 32'h00000000};
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLAVE_MASK =
    {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFC000000, 32'hFFFF8000};
  function automatic int sel_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder: combinational base/mask match returning a hit flag and the lowest matching slave index.
module wb_addr_decoder import wb_ic_pkg::*; #(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int IDX_WIDTH = sel_idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic                  hit,
  output logic [IDX_WIDTH-1:0]  idx
);
  // Scan high to low so the lowest matching index wins on overlap.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((adr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
  end
endmodule

// File: rtl/wb_interconnect_1xn.sv
// wb_interconnect_1xn: single-master N-slave Wishbone classic interconnect with registered slave select and error termination.
// Define WB_INTERCONNECT_TIMEOUT_EN to terminate hung slaves with an error after TIMEOUT_CYCLES.
module wb_interconnect_1xn import wb_ic_pkg::*; #(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]          wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]          wbm_dat_i,
  output logic [DATA_WIDTH-1:0]          wbm_dat_o,
  input  logic                           wbm_we_i,
  input  logic [DATA_WIDTH/8-1:0]        wbm_sel_i,
  input  logic                           wbm_stb_i,
  input  logic                           wbm_cyc_i,
  output logic                           wbm_ack_o,
  output logic                           wbm_err_o,
  output logic [ADDR_WIDTH-1:0]          wbs_adr_o,
  output logic [DATA_WIDTH-1:0]          wbs_dat_o,
  output logic                           wbs_we_o,
  output logic [DATA_WIDTH/8-1:0]        wbs_sel_o,
  output logic [NUM_SLAVES-1:0]          wbs_stb_o,
  output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]          wbs_ack_i,
  output logic                           err_flag_o,
  output logic [ADDR_WIDTH-1:0]          err_adr_o,
  input  logic                           err_clr_i
);
  localparam int SW = sel_idx_width(NUM_SLAVES);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  logic [1:0] state, state_nx;
  logic [SW-1:0] sel, dec_idx;
  logic [NUM_SLAVES-1:0] onehot;
  logic dec_hit, req, active, slv_ack, timeout;
  wb_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
    .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK), .IDX_WIDTH(SW)
  ) u_dec (
    .adr(wbm_adr_i),
    .hit(dec_hit),
    .idx(dec_idx)
  );
  assign req = wbm_cyc_i & wbm_stb_i;
  assign active = state == ACTIVE;
  assign slv_ack = wbs_ack_i[sel] & wbm_cyc_i;
  assign onehot = NUM_SLAVES'(1) << sel;
  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_we_o = wbm_we_i;
  assign wbs_sel_o = wbm_sel_i;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  // Counter is held at zero outside ACTIVE, so every new transaction starts fresh.
  logic [7:0] cnt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) cnt <= '0;
    else cnt <= (active && !slv_ack) ? cnt + 8'd1 : '0;
  assign timeout = cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      sel <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) sel <= dec_idx;
    end
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = req ? (dec_hit ? ACTIVE : ERR) : IDLE;
    else if (active) state_nx = (!wbm_cyc_i || slv_ack) ? IDLE : (timeout ? ERR : ACTIVE);
  end
  always_comb begin
    wbs_cyc_o = (active && wbm_cyc_i) ? onehot : '0;
    wbs_stb_o = (active && req) ? onehot : '0;
    wbm_ack_o = active & slv_ack;
    wbm_err_o = state == ERR;
    wbm_dat_o = active ? wbs_dat_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  // An error in the same cycle as a clear starts a fresh capture.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      err_flag_o <= 1'b0;
      err_adr_o <= '0;
    end else if (state == ERR) begin
      err_flag_o <= 1'b1;
      if (!err_flag_o || err_clr_i) err_adr_o <= wbm_adr_i;
    end else if (err_clr_i) begin
      err_flag_o <= 1'b0;
      err_adr_o <= '0;
    end
endmodule
